// File: rtl/fifo_video_reader.sv
// Read-side drain controller for the asynchronous pixel FIFO: generates video timing
// in the read clock domain, pops one word per active pixel and fills in on underflow.
module fifo_video_reader #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    H_ACTIVE   = 1920,
  parameter int                    H_FP       = 88,
  parameter int                    H_SYNC     = 44,
  parameter int                    H_BP       = 148,
  parameter int                    V_ACTIVE   = 1080,
  parameter int                    V_FP       = 4,
  parameter int                    V_SYNC     = 5,
  parameter int                    V_BP       = 36,
  parameter int                    SYNC_POL   = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_COLOR = '0
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_almost_empty,
  output logic                  vid_hs,
  output logic                  vid_vs,
  output logic                  vid_de,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  frame_start,
  output logic                  underflow,
  output logic [15:0]           underflow_cnt,
  output logic [1:0]            dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SP       = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          frame_uf;

  logic run, in_active, hs_raw, vs_raw, h_last, v_last, pop_now, uf_now;

  assign dbg_state = state;

  always_comb begin
    run       = (state == RUN);
    h_last    = (h_cnt == H_LAST);
    v_last    = (v_cnt == V_LAST);
    in_active = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw    = run && (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
    vs_raw    = run && (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);
    pop_now   = in_active && !fifo_rd_empty;
    uf_now    = in_active && fifo_rd_empty;
  end

  // Mode control and raster counters; a started frame always runs to its last clock.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state    <= IDLE;
      h_cnt    <= '0;
      v_cnt    <= '0;
      frame_uf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (enable) state <= WAIT_FILL;
        end
        WAIT_FILL: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (!enable)                 state <= IDLE;
          else if (!fifo_almost_empty) state <= RUN;
        end
        RUN: begin
          if (uf_now) frame_uf <= 1'b1;
          if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
              v_cnt    <= '0;
              frame_uf <= 1'b0;
              if (!enable)       state <= IDLE;
              else if (frame_uf) state <= WAIT_FILL;
            end else begin
              v_cnt <= v_cnt + VW'(1);
            end
          end else begin
            h_cnt <= h_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic de0, hs0, vs0, fs0;
  logic de1, hs1, vs1, fs1, pop1;

  // FIFO handshake: fifo_rd_en is a registered pop strobe, only raised while the FIFO
  // reports non-empty; the popped word is presented on fifo_rd_data during the following
  // cycle and is captured by the output stage at the end of that cycle.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      fifo_rd_en    <= 1'b0;
      de0           <= 1'b0;
      hs0           <= 1'b0;
      vs0           <= 1'b0;
      fs0           <= 1'b0;
      de1           <= 1'b0;
      hs1           <= 1'b0;
      vs1           <= 1'b0;
      fs1           <= 1'b0;
      pop1          <= 1'b0;
      vid_de        <= 1'b0;
      vid_hs        <= ~SP;
      vid_vs        <= ~SP;
      vid_data      <= '0;
      frame_start   <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      fifo_rd_en  <= pop_now;
      de0         <= in_active;
      hs0         <= hs_raw;
      vs0         <= vs_raw;
      fs0         <= run && (h_cnt == '0) && (v_cnt == '0);
      de1         <= de0;
      hs1         <= hs0;
      vs1         <= vs0;
      fs1         <= fs0;
      pop1        <= fifo_rd_en;
      vid_de      <= de1;
      vid_hs      <= hs1 ? SP : ~SP;
      vid_vs      <= vs1 ? SP : ~SP;
      vid_data    <= de1 ? (pop1 ? fifo_rd_data : FILL_COLOR) : '0;
      frame_start <= fs1;
      if (uf_now) begin
        underflow <= 1'b1;
        if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_video_reader.sv
// Bench for fifo_video_reader: small-raster instance checked against a frame-position
// model every cycle, plus a large-raster instance used to drive the counter into saturation.
`timescale 1ns/1ps
module tb_fifo_video_reader;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam logic [23:0] FILL = 24'hABCDEF;
  localparam int AE_LVL = 2;
  localparam int SA = 300, ST = 303;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] data;
  } pix_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic rst_s_n = 1'b0;
  logic enable = 1'b0;

  // ---------------- DUT signals ----------------
  logic        fifo_rd_en;
  logic [23:0] fifo_rd_data = '0;
  logic        fifo_rd_empty = 1'b1;
  logic        fifo_almost_empty = 1'b1;
  logic        vid_hs, vid_vs, vid_de, frame_start, underflow;
  logic [23:0] vid_data;
  logic [15:0] underflow_cnt;
  logic [1:0]  dbg_state;

  fifo_video_reader #(
    .DATA_WIDTH(24), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1), .FILL_COLOR(FILL)
  ) u_dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_almost_empty(fifo_almost_empty),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
    .frame_start(frame_start), .underflow(underflow), .underflow_cnt(underflow_cnt),
    .dbg_state(dbg_state)
  );

  logic        s_rd_en, s_hs, s_vs, s_de, s_fs, s_uf;
  logic [23:0] s_data;
  logic [15:0] s_cnt;
  logic [1:0]  s_state;

  fifo_video_reader #(
    .DATA_WIDTH(24), .H_ACTIVE(SA), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(SA), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1), .FILL_COLOR(FILL)
  ) u_sat (
    .rd_clk(clk), .rd_rst_n(rst_s_n), .enable(1'b1),
    .fifo_rd_en(s_rd_en), .fifo_rd_data(24'h0),
    .fifo_rd_empty(1'b1), .fifo_almost_empty(1'b0),
    .vid_hs(s_hs), .vid_vs(s_vs), .vid_de(s_de), .vid_data(s_data),
    .frame_start(s_fs), .underflow(s_uf), .underflow_cnt(s_cnt),
    .dbg_state(s_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model (pops presented one cycle after the strobe) ----------------
  logic [23:0] fifo_q[$];
  logic [23:0] exp_q[$];
  bit pend = 1'b0;
  int pops = 0;

  always @(negedge clk) begin
    int eff;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        total++;
        if (fifo_q.size() == 0) begin
          bad++;
          $display("FAIL fifo_underrun: pop with 0 words, required >0 at %0t", $time);
        end else begin
          fifo_rd_data = fifo_q.pop_front();
          pops++;
        end
      end
      pend = fifo_rd_en;
    end
    eff = fifo_q.size() - int'(pend);
    fifo_rd_empty     = (eff <= 0);
    fifo_almost_empty = (eff < AE_LVL);
  end

  task automatic preload(input int n);
    for (int i = 1; i <= n; i++) begin
      fifo_q.push_back(24'(i));
      exp_q.push_back(24'(i));
    end
  endtask

  // ---------------- behavioural model: linear frame position + output delay queue ----------------
  int          m_state = 0;
  int          m_pos = 0;
  bit          m_uf_frame = 1'b0;
  logic        m_rd_en = 1'b0;
  logic        m_underflow = 1'b0;
  logic [15:0] m_cnt = '0;
  pix_t        out_q[$];

  initial begin
    out_q.push_back('0);
    out_q.push_back('0);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_pos = 0; m_uf_frame = 1'b0;
      m_rd_en = 1'b0; m_underflow = 1'b0; m_cnt = '0;
      out_q = {};
      out_q.push_back('0);
      out_q.push_back('0);
    end else begin : mdl
      int h, v;
      bit run, act;
      pix_t p;
      h = m_pos % HT;
      v = m_pos / HT;
      run = (m_state == 2);
      act = run && (h < HA) && (v < VA);
      p = '0;
      p.de = act;
      p.hs = run && (h >= HA + HF) && (h < HA + HF + HS);
      p.vs = run && (v >= VA + VF) && (v < VA + VF + VS);
      p.fs = run && (m_pos == 0);
      if (act && !fifo_rd_empty) p.data = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      else if (act)              p.data = FILL;
      out_q.push_back(p);
      m_rd_en = act && !fifo_rd_empty;
      if (act && fifo_rd_empty) begin
        m_underflow = 1'b1;
        m_uf_frame = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      case (m_state)
        0: if (enable) m_state = 1;
        1: if (!enable) m_state = 0; else if (!fifo_almost_empty) m_state = 2;
        default: begin
          if (m_pos == HT * VT - 1) begin
            m_pos = 0;
            m_state = !enable ? 0 : (m_uf_frame ? 1 : 2);
            m_uf_frame = 1'b0;
          end else begin
            m_pos++;
          end
        end
      endcase
    end
  end

  // ---------------- saturation instance model ----------------
  int          ms_state = 0;
  int          ms_pos = 0;
  int          ms_act_total = 0;
  logic [15:0] ms_cnt = '0;

  always @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      ms_state = 0; ms_pos = 0; ms_act_total = 0; ms_cnt = '0;
    end else begin
      case (ms_state)
        0: ms_state = 1;
        1: ms_state = 2;
        default: begin
          if ((ms_pos % ST) < SA && (ms_pos / ST) < SA) begin
            ms_act_total++;
            if (ms_cnt != 16'hFFFF) ms_cnt++;
          end
          if (ms_pos == ST * ST - 1) begin
            ms_pos = 0;
            ms_state = 1;
          end else begin
            ms_pos++;
          end
        end
      endcase
    end
  end

  // ---------------- compare process + frame capture ----------------
  int lg_req = 0, lg_used = 0, lg_n = 48, lg_frames = 0;
  logic        lg_de[48], lg_hs[48], lg_vs[48];
  logic [23:0] lg_data[48];

  always @(negedge clk) begin
    pix_t e;
    if (rst_n) begin
      e = (out_q.size() >= 3) ? out_q.pop_front() : '0;
      check("vid_de", vid_de, e.de);
      check("vid_hs", vid_hs, e.hs);
      check("vid_vs", vid_vs, e.vs);
      check("vid_data", vid_data, e.data);
      check("frame_start", frame_start, e.fs);
      check("fifo_rd_en", fifo_rd_en, m_rd_en);
      check("underflow", underflow, m_underflow);
      check("underflow_cnt", underflow_cnt, m_cnt);
      check("dbg_state", dbg_state, m_state);
      if (frame_start === 1'b1 && lg_used != lg_req) begin
        lg_used = lg_req;
        lg_n = 0;
      end
      if (lg_n < 48) begin
        lg_de[lg_n] = vid_de; lg_hs[lg_n] = vid_hs;
        lg_vs[lg_n] = vid_vs; lg_data[lg_n] = vid_data;
        lg_n++;
        if (lg_n == 48) lg_frames++;
      end
    end
    if (rst_s_n) begin
      check("sat_underflow_cnt", s_cnt, ms_cnt);
      check("sat_fifo_rd_en", s_rd_en, 1'b0);
    end
  end

  // ---------------- driver / wait tasks ----------------
  task automatic wait_state(input int s, input int max, input string nm);
    int n = 0;
    while (m_state != s && n < max) begin @(negedge clk); n++; end
    check({"wait_", nm}, m_state, s);
  endtask

  task automatic wait_pos(input int p, input int max);
    int n = 0;
    while (!(m_state == 2 && m_pos == p) && n < max) begin @(negedge clk); n++; end
    check("wait_pos", m_pos, p);
  endtask

  task automatic wait_frame(input int f0, input int max);
    int n = 0;
    while (lg_frames == f0 && n < max) begin @(negedge clk); n++; end
    check("wait_frame_capture", lg_frames, f0 + 1);
  endtask

  // Hand-derived raster: 8 clocks/line, de on h<4 of lines 0-2, hs on h=5,6, vs on line 4.
  task automatic check_frame(input int nwords, input string tag);
    for (int k = 0; k < 48; k++) begin
      int h, v, n;
      bit de;
      logic [23:0] d;
      h = k % 8; v = k / 8; n = v * 4 + h;
      de = (h < 4) && (v < 3);
      d = !de ? 24'h0 : (n < nwords ? 24'(n + 1) : 24'hABCDEF);
      check($sformatf("%s_de[%0d]", tag, k), lg_de[k], de);
      check($sformatf("%s_hs[%0d]", tag, k), lg_hs[k], (h == 5) || (h == 6));
      check($sformatf("%s_vs[%0d]", tag, k), lg_vs[k], v == 4);
      check($sformatf("%s_data[%0d]", tag, k), lg_data[k], d);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0, f0, n;
    preload(12);
    #22 rst_n = 1'b1; rst_s_n = 1'b1;

    // 1: disabled with a full FIFO
    repeat (100) @(negedge clk);
    check("t1_rd_en", fifo_rd_en, 1'b0);
    check("t1_vid_de", vid_de, 1'b0);
    check("t1_vid_data", vid_data, 24'h0);
    check("t1_underflow_cnt", underflow_cnt, 16'h0);
    check("t1_pops", pops, 0);

    // 2 + 4: full frame of 12 words, enable dropped at h=2 v=1
    p0 = pops; f0 = lg_frames; lg_req++;
    enable = 1'b1;
    @(negedge clk); check("t2_wait_fill", dbg_state, 2'd1);
    @(negedge clk); check("t2_run", dbg_state, 2'd2);
    wait_pos(10, 40);
    enable = 1'b0;
    wait_frame(f0, 100);
    wait_state(0, 60, "t4_idle");
    check_frame(12, "t2");
    check("t2_pops", pops - p0, 12);
    check("t2_underflow", underflow, 1'b0);
    repeat (10) @(negedge clk);
    check("t4_no_pops", pops - p0, 12);

    // 3: 8 words -> line 2 filled, back to WAIT_FILL
    p0 = pops; f0 = lg_frames; lg_req++;
    preload(8);
    @(negedge clk);
    enable = 1'b1;
    wait_state(2, 10, "t3_run");
    wait_frame(f0, 100);
    wait_state(1, 60, "t3_wait_fill");
    check_frame(8, "t3");
    check("t3_underflow", underflow, 1'b1);
    check("t3_underflow_cnt", underflow_cnt, 16'd4);
    check("t3_pops", pops - p0, 8);
    repeat (20) @(negedge clk);
    check("t3_held_state", dbg_state, 2'd1);
    check("t3_held_de", vid_de, 1'b0);

    // 5: asynchronous reset mid-line with de high
    preload(12);
    wait_state(2, 10, "t5_run");
    n = 0;
    while (vid_de !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("t5_de_seen", vid_de, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_de", vid_de, 1'b0);
    check("t5_rst_hs", vid_hs, 1'b0);
    check("t5_rst_vs", vid_vs, 1'b0);
    check("t5_rst_data", vid_data, 24'h0);
    check("t5_rst_fs", frame_start, 1'b0);
    check("t5_rst_rd_en", fifo_rd_en, 1'b0);
    check("t5_rst_underflow", underflow, 1'b0);
    check("t5_rst_cnt", underflow_cnt, 16'h0);
    check("t5_rst_state", dbg_state, 2'd0);
    fifo_q.delete();
    exp_q.delete();
    preload(12);
    f0 = lg_frames; lg_req++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_state(2, 10, "t5_rerun");
    wait_pos(20, 40);
    enable = 1'b0;
    wait_frame(f0, 100);
    wait_state(0, 60, "t5_idle");
    check_frame(12, "t5");
    check("t5_underflow_cnt", underflow_cnt, 16'h0);

    // 6: saturation instance, empty FIFO for 70000 active pixels
    n = 0;
    while (ms_act_total < 70000 && n < 80000) begin @(negedge clk); n++; end
    check("t6_active_pixels", ms_act_total, 70000);
    repeat (2) @(negedge clk);
    check("t6_sat_cnt", s_cnt, 16'hFFFF);
    check("t6_sat_underflow", s_uf, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
